abm_block_mover: RTL and testbench



---
 rtl/abm_block_mover.sv | 260 ++++++++++++++++++++++++++
 tb/tb_abm_block_mover.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abm_block_mover.sv
// abm_block_mover: single-master AXI4-MM block copier.
// Each burst is read from the source slave into a MAX_BEATS-deep staging
// buffer, then written out to the destination slave. Bursts never cross a
// 4 KB page on either side.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   src_addr, dst_addr   byte addresses (DW/8 aligned, src nonzero)
//   byte_count           bytes to move (nonzero multiple of DW/8)
//   burst_beats          requested beats per burst (1..MAX_BEATS)
//   start, abort         start pulse (idle only), abort level (burst boundary)
//   idle, status         idle flag; sticky {cfg_reject, bresp_err, rresp_err}
//   beats_done           beats written and acknowledged in this transfer
//   SRC_AXI_AR*/R*       source read master
//   DST_AXI_AW*/W*/B*    destination write master
module abm_block_mover #(
  parameter int DW        = 512,
  parameter int AW        = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   src_addr,
  input  logic [AW-1:0]   dst_addr,
  input  logic [31:0]     byte_count,
  input  logic [8:0]      burst_beats,
  input  logic            start,
  input  logic            abort,
  output logic            idle,
  output logic [2:0]      status,
  output logic [31:0]     beats_done,
  output logic [AW-1:0]   SRC_AXI_ARADDR,
  output logic            SRC_AXI_ARVALID,
  output logic [7:0]      SRC_AXI_ARLEN,
  output logic [2:0]      SRC_AXI_ARSIZE,
  output logic [1:0]      SRC_AXI_ARBURST,
  output logic [3:0]      SRC_AXI_ARID,
  output logic            SRC_AXI_ARLOCK,
  output logic [3:0]      SRC_AXI_ARCACHE,
  output logic [3:0]      SRC_AXI_ARQOS,
  output logic [2:0]      SRC_AXI_ARPROT,
  input  logic            SRC_AXI_ARREADY,
  input  logic [DW-1:0]   SRC_AXI_RDATA,
  input  logic            SRC_AXI_RVALID,
  input  logic [1:0]      SRC_AXI_RRESP,
  input  logic            SRC_AXI_RLAST,
  output logic            SRC_AXI_RREADY,
  output logic [AW-1:0]   DST_AXI_AWADDR,
  output logic            DST_AXI_AWVALID,
  output logic [7:0]      DST_AXI_AWLEN,
  output logic [2:0]      DST_AXI_AWSIZE,
  output logic [1:0]      DST_AXI_AWBURST,
  output logic [3:0]      DST_AXI_AWID,
  output logic            DST_AXI_AWLOCK,
  output logic [3:0]      DST_AXI_AWCACHE,
  output logic [3:0]      DST_AXI_AWQOS,
  output logic [2:0]      DST_AXI_AWPROT,
  input  logic            DST_AXI_AWREADY,
  output logic [DW-1:0]   DST_AXI_WDATA,
  output logic [DW/8-1:0] DST_AXI_WSTRB,
  output logic            DST_AXI_WVALID,
  output logic            DST_AXI_WLAST,
  input  logic            DST_AXI_WREADY,
  input  logic [1:0]      DST_AXI_BRESP,
  input  logic            DST_AXI_BVALID,
  output logic            DST_AXI_BREADY
);

  localparam int BPB  = DW / 8;
  localparam int SIZE = $clog2(BPB);
  localparam int IW   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [8:0] MAXB = 9'(MAX_BEATS);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_AW, S_WR, S_BR} state_t;

  state_t        state_q;
  logic          idle_q;
  logic [2:0]    status_q;
  logic [31:0]   beats_q, rem_q;
  logic [AW-1:0] src_q, dst_q;
  logic [8:0]    bb_q, len_q, idx_q;
  logic          arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [AW-1:0] araddr_q, awaddr_q;
  logic [7:0]    arlen_q, awlen_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem_q [MAX_BEATS];

  logic          legal;
  logic [8:0]    len_first, len_next;
  logic [AW-1:0] src_nx, dst_nx;
  logic [31:0]   rem_nx;
  logic [2:0]    status_b;

  // Burst length clipped to remaining work and to both 4 KB pages.
  function automatic logic [8:0] calc_len(input logic [11:0] s, input logic [11:0] d,
                                          input logic [31:0] rem, input logic [8:0] bb);
    logic [31:0] l, ps, pd;
    l  = {23'd0, bb};
    ps = (32'd4096 - {20'd0, s}) >> SIZE;
    pd = (32'd4096 - {20'd0, d}) >> SIZE;
    if (rem < l) l = rem;
    if (ps < l)  l = ps;
    if (pd < l)  l = pd;
    return 9'(l);
  endfunction

  always_comb begin
    legal = (src_addr != '0) && (src_addr[SIZE-1:0] == '0) && (dst_addr[SIZE-1:0] == '0) &&
            (byte_count != '0) && (byte_count[SIZE-1:0] == '0) &&
            (burst_beats != '0) && (burst_beats <= MAXB);
    len_first = calc_len(src_addr[11:0], dst_addr[11:0], byte_count >> SIZE, burst_beats);
    src_nx    = src_q + (AW'(len_q) << SIZE);
    dst_nx    = dst_q + (AW'(len_q) << SIZE);
    rem_nx    = rem_q - 32'(len_q);
    len_next  = calc_len(src_nx[11:0], dst_nx[11:0], rem_nx, bb_q);
    status_b  = status_q | {1'b0, (DST_AXI_BRESP != 2'b00), 1'b0};
  end

  // Staging buffer: no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_RD && SRC_AXI_RVALID && idx_q < MAXB)
      mem_q[idx_q[IW-1:0]] <= SRC_AXI_RDATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idle_q    <= 1'b1;
      status_q  <= '0;
      beats_q   <= '0;
      rem_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      bb_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          if (legal) begin
            status_q  <= '0;
            beats_q   <= '0;
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            rem_q     <= byte_count >> SIZE;
            bb_q      <= burst_beats;
            len_q     <= len_first;
            idle_q    <= 1'b0;
            arvalid_q <= 1'b1;
            araddr_q  <= src_addr;
            arlen_q   <= 8'(len_first - 9'd1);
            state_q   <= S_AR;
          end else begin
            status_q[2] <= 1'b1;
          end
        end
        S_AR: if (SRC_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          idx_q     <= '0;
          state_q   <= S_RD;
        end
        S_RD: if (SRC_AXI_RVALID) begin
          idx_q <= idx_q + 9'd1;
          if (SRC_AXI_RRESP != 2'b00) status_q[0] <= 1'b1;
          if (SRC_AXI_RLAST) begin
            // A short or long burst is flagged but the write still goes out.
            if (idx_q + 9'd1 != len_q) status_q[0] <= 1'b1;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b1;
            awaddr_q  <= dst_q;
            awlen_q   <= 8'(len_q - 9'd1);
            state_q   <= S_AW;
          end
        end
        S_AW: if (DST_AXI_AWREADY) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wdata_q   <= mem_q[0];
          wlast_q   <= (len_q == 9'd1);
          idx_q     <= 9'd1;
          state_q   <= S_WR;
        end
        S_WR: if (DST_AXI_WREADY) begin
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= S_BR;
          end else begin
            // Prefetch the next beat so handshakes run back-to-back.
            wdata_q <= mem_q[idx_q[IW-1:0]];
            wlast_q <= (idx_q == len_q - 9'd1);
            idx_q   <= idx_q + 9'd1;
          end
        end
        S_BR: if (DST_AXI_BVALID) begin
          bready_q <= 1'b0;
          status_q <= status_b;
          beats_q  <= beats_q + 32'(len_q);
          rem_q    <= rem_nx;
          src_q    <= src_nx;
          dst_q    <= dst_nx;
          if (rem_nx == '0 || status_b[1:0] != 2'b00 || abort) begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            len_q     <= len_next;
            arvalid_q <= 1'b1;
            araddr_q  <= src_nx;
            arlen_q   <= 8'(len_next - 9'd1);
            state_q   <= S_AR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idle            = idle_q;
  assign status          = status_q;
  assign beats_done      = beats_q;
  assign SRC_AXI_ARADDR  = araddr_q;
  assign SRC_AXI_ARVALID = arvalid_q;
  assign SRC_AXI_ARLEN   = arlen_q;
  assign SRC_AXI_ARSIZE  = 3'(SIZE);
  assign SRC_AXI_ARBURST = 2'b01;
  assign SRC_AXI_ARID    = '0;
  assign SRC_AXI_ARLOCK  = 1'b0;
  assign SRC_AXI_ARCACHE = '0;
  assign SRC_AXI_ARQOS   = '0;
  assign SRC_AXI_ARPROT  = '0;
  assign SRC_AXI_RREADY  = rready_q;
  assign DST_AXI_AWADDR  = awaddr_q;
  assign DST_AXI_AWVALID = awvalid_q;
  assign DST_AXI_AWLEN   = awlen_q;
  assign DST_AXI_AWSIZE  = 3'(SIZE);
  assign DST_AXI_AWBURST = 2'b01;
  assign DST_AXI_AWID    = '0;
  assign DST_AXI_AWLOCK  = 1'b0;
  assign DST_AXI_AWCACHE = '0;
  assign DST_AXI_AWQOS   = '0;
  assign DST_AXI_AWPROT  = '0;
  assign DST_AXI_WDATA   = wdata_q;
  assign DST_AXI_WSTRB   = '1;
  assign DST_AXI_WVALID  = wvalid_q;
  assign DST_AXI_WLAST   = wlast_q;
  assign DST_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_abm_block_mover.sv
// Testbench for abm_block_mover: randomized AXI slave models with a
// page-splitting reference model and a destination memory scoreboard.
module tb_abm_block_mover;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int MB  = 64;
  localparam int BPB = DW / 8;

  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [31:0] byte_count = '0;
  logic [8:0] burst_beats = '0;
  logic start = 1'b0, abort = 1'b0;
  logic idle;
  logic [2:0] status;
  logic [31:0] beats_done;
  logic [AW-1:0] ARADDR, AWADDR;
  logic ARVALID, ARLOCK, AWVALID, AWLOCK, WVALID, WLAST, BREADY, RREADY;
  logic [7:0] ARLEN, AWLEN;
  logic [2:0] ARSIZE, ARPROT, AWSIZE, AWPROT;
  logic [1:0] ARBURST, AWBURST;
  logic [3:0] ARID, ARCACHE, ARQOS, AWID, AWCACHE, AWQOS;
  logic [DW-1:0] WDATA;
  logic [BPB-1:0] WSTRB;
  logic ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [1:0] RRESP = '0, BRESP = '0;

  abm_block_mover #(.DW(DW), .AW(AW), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset), .src_addr(src_addr), .dst_addr(dst_addr),
    .byte_count(byte_count), .burst_beats(burst_beats), .start(start), .abort(abort),
    .idle(idle), .status(status), .beats_done(beats_done),
    .SRC_AXI_ARADDR(ARADDR), .SRC_AXI_ARVALID(ARVALID), .SRC_AXI_ARLEN(ARLEN),
    .SRC_AXI_ARSIZE(ARSIZE), .SRC_AXI_ARBURST(ARBURST), .SRC_AXI_ARID(ARID),
    .SRC_AXI_ARLOCK(ARLOCK), .SRC_AXI_ARCACHE(ARCACHE), .SRC_AXI_ARQOS(ARQOS),
    .SRC_AXI_ARPROT(ARPROT), .SRC_AXI_ARREADY(ARREADY),
    .SRC_AXI_RDATA(RDATA), .SRC_AXI_RVALID(RVALID), .SRC_AXI_RRESP(RRESP),
    .SRC_AXI_RLAST(RLAST), .SRC_AXI_RREADY(RREADY),
    .DST_AXI_AWADDR(AWADDR), .DST_AXI_AWVALID(AWVALID), .DST_AXI_AWLEN(AWLEN),
    .DST_AXI_AWSIZE(AWSIZE), .DST_AXI_AWBURST(AWBURST), .DST_AXI_AWID(AWID),
    .DST_AXI_AWLOCK(AWLOCK), .DST_AXI_AWCACHE(AWCACHE), .DST_AXI_AWQOS(AWQOS),
    .DST_AXI_AWPROT(AWPROT), .DST_AXI_AWREADY(AWREADY),
    .DST_AXI_WDATA(WDATA), .DST_AXI_WSTRB(WSTRB), .DST_AXI_WVALID(WVALID),
    .DST_AXI_WLAST(WLAST), .DST_AXI_WREADY(WREADY),
    .DST_AXI_BRESP(BRESP), .DST_AXI_BVALID(BVALID), .DST_AXI_BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int unsigned stall_pct = 0, seed;
  int err_beat = -1, rd_glob = 0;

  // Reference model: expected burst list.
  longint unsigned exp_src[$], exp_dst[$];
  int unsigned exp_len[$];
  // Observations and slave state.
  logic [AW-1:0] obs_ar_addr[$], obs_aw_addr[$], rq_addr[$], wq_addr[$];
  logic [7:0] obs_ar_len[$], obs_aw_len[$];
  int unsigned rq_len[$];
  logic [DW-1:0] dmem [longint unsigned];
  logic r_act = 0, r_hs = 0, b_hs = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic [AW-1:0] r_addr;
  int unsigned r_len, r_beat, w_beat, w_bidx, b_pend, b_cnt;
  logic [71:0] ar_sv, aw_sv;
  logic [DW-1:0] w_sv;
  logic wlast_sv;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] srcword(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++)
      w[k*32 +: 32] = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ (32'(k) * 32'h01000193) ^ seed;
    return w;
  endfunction

  function automatic logic rnd();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  task automatic build_exp(input longint unsigned s, input longint unsigned d,
                           input longint unsigned bytes, input int unsigned bb);
    longint unsigned rem, l;
    exp_src.delete(); exp_dst.delete(); exp_len.delete();
    rem = bytes / BPB;
    while (rem > 0) begin
      l = bb;
      if (rem < l) l = rem;
      if ((4096 - s % 4096) / BPB < l) l = (4096 - s % 4096) / BPB;
      if ((4096 - d % 4096) / BPB < l) l = (4096 - d % 4096) / BPB;
      exp_src.push_back(s); exp_dst.push_back(d); exp_len.push_back(int'(l));
      s += l * BPB; d += l * BPB; rem -= l;
    end
  endtask

  task automatic slave_step();
    if (reset) begin
      ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
      r_act = 0; r_hs = 0; b_hs = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
      rq_addr.delete(); rq_len.delete(); wq_addr.delete(); w_beat = 0; b_pend = 0;
      return;
    end
    if (ar_wait) check("ar_hold", {ARVALID, ARADDR, ARLEN}, {1'b1, ar_sv});
    if (aw_wait) check("aw_hold", {AWVALID, AWADDR, AWLEN}, {1'b1, aw_sv});
    if (w_wait) begin
      check("w_hold_data", WDATA, w_sv);
      check("w_hold_ctl", {WVALID, WLAST}, {1'b1, wlast_sv});
    end
    // AR
    ARREADY = rnd();
    if (ARVALID && ARREADY) begin
      obs_ar_addr.push_back(ARADDR); obs_ar_len.push_back(ARLEN);
      rq_addr.push_back(ARADDR); rq_len.push_back(int'(ARLEN) + 1);
    end
    ar_wait = ARVALID && !ARREADY; ar_sv = {ARADDR, ARLEN};
    // R
    if (r_hs) RVALID = 0;
    r_hs = 0;
    if (!r_act && rq_addr.size() > 0) begin
      r_addr = rq_addr.pop_front(); r_len = rq_len.pop_front(); r_beat = 0; r_act = 1;
    end
    if (r_act) begin
      if (!RVALID) RVALID = rnd();
      RDATA = srcword(r_addr + AW'(r_beat * BPB));
      RLAST = (r_beat == r_len - 1);
      RRESP = (err_beat >= 0 && rd_glob == err_beat) ? 2'b10 : 2'b00;
      if (RVALID && RREADY) begin
        r_hs = 1; r_beat++; rd_glob++;
        if (RLAST) r_act = 0;
      end
    end else begin
      RVALID = 0; RLAST = 0;
    end
    // AW
    AWREADY = rnd();
    if (AWVALID && AWREADY) begin
      obs_aw_addr.push_back(AWADDR); obs_aw_len.push_back(AWLEN); wq_addr.push_back(AWADDR);
    end
    aw_wait = AWVALID && !AWREADY; aw_sv = {AWADDR, AWLEN};
    // W
    WREADY = rnd();
    if (WVALID && WREADY) begin
      check("wstrb", WSTRB, {BPB{1'b1}});
      if (wq_addr.size() == 0 || w_bidx >= exp_len.size()) check("w_unexpected", 1'b1, 1'b0);
      else begin
        dmem[wq_addr[0] + AW'(w_beat * BPB)] = WDATA;
        check("wlast", WLAST, w_beat == exp_len[w_bidx] - 1);
        w_beat++;
        if (WLAST) begin
          void'(wq_addr.pop_front()); w_beat = 0; w_bidx++; b_pend++;
        end
      end
    end
    w_wait = WVALID && !WREADY; w_sv = WDATA; wlast_sv = WLAST;
    // B
    if (b_hs) BVALID = 0;
    b_hs = 0;
    if (!BVALID && b_pend > 0) BVALID = rnd();
    BRESP = 2'b00;
    if (BVALID && BREADY) begin
      b_pend--; b_cnt++; b_hs = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic clear_obs();
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_aw_addr.delete(); obs_aw_len.delete();
    dmem.delete(); rd_glob = 0; w_bidx = 0; b_cnt = 0;
  endtask

  // nexp < 0 means every burst of the model is expected.
  task automatic run_xfer(input longint unsigned s, input longint unsigned d,
                          input int unsigned bytes, input int unsigned bb,
                          input int nexp, input logic [2:0] exp_st,
                          input logic do_abort, input logic poke);
    int unsigned cyc, n, sum;
    clear_obs();
    build_exp(s, d, bytes, bb);
    src_addr = s; dst_addr = d; byte_count = bytes; burst_beats = 9'(bb); start = 1;
    tick();
    start = 0;
    check("start_to_arvalid", ARVALID, 1'b1);
    check("busy_idle", idle, 1'b0);
    if (do_abort) abort = 1;
    cyc = 0;
    while (!idle && cyc < 20000) begin
      if (poke && cyc == 20) begin
        src_addr = 64'h2000; dst_addr = 64'h3000; byte_count = 64; burst_beats = 1; start = 1;
      end
      tick();
      start = 0;
      cyc++;
    end
    if (!idle) check("timeout_idle", 1'b0, 1'b1);
    abort = 0;
    repeat (6) tick();
    n = (nexp < 0) ? exp_len.size() : nexp;
    check("n_ar", obs_ar_addr.size(), n);
    check("n_aw", obs_aw_addr.size(), n);
    check("n_b", b_cnt, n);
    sum = 0;
    for (int unsigned i = 0; i < n; i++) begin
      sum += exp_len[i];
      if (i < obs_ar_addr.size()) begin
        check("araddr", obs_ar_addr[i], exp_src[i]);
        check("arlen", obs_ar_len[i], exp_len[i] - 1);
      end
      if (i < obs_aw_addr.size()) begin
        check("awaddr", obs_aw_addr[i], exp_dst[i]);
        check("awlen", obs_aw_len[i], exp_len[i] - 1);
      end
    end
    check("beats_done", beats_done, sum);
    check("status", status, exp_st);
    check("idle_end", idle, 1'b1);
    for (int unsigned j = 0; j < sum; j++) begin
      longint unsigned a;
      a = d + j * BPB;
      check("data", dmem.exists(a) ? dmem[a] : {DW{1'bx}}, srcword(s + j * BPB));
    end
  endtask

  initial begin
    seed = $urandom;
    repeat (3) tick();
    check("rst_idle", idle, 1'b1);
    check("rst_status", status, 3'b000);
    check("rst_beats", beats_done, 0);
    check("rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
    check("rst_addr_len", {ARADDR, ARLEN, AWADDR, AWLEN}, 0);
    reset = 0;
    tick();
    check("const_ar", {ARSIZE, ARBURST, ARID, ARLOCK, ARCACHE, ARQOS, ARPROT}, {3'd6, 2'b01, 16'd0});
    check("const_aw", {AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWQOS, AWPROT}, {3'd6, 2'b01, 16'd0});

    stall_pct = 0;
    run_xfer(64'h1_0000_0000, 64'h0, 8192, 64, -1, 3'b000, 0, 0);
    run_xfer(64'h1_0000_0F00, 64'h0, 4096, 64, -1, 3'b000, 0, 0);
    stall_pct = 35;
    run_xfer(64'h1_0000_0000, 64'h4000, 12288, 64, -1, 3'b000, 0, 0);
    for (int t = 0; t < 6; t++)
      run_xfer(64'h1_0000_0000 + 64'($urandom_range(15)) * 4096 + 64'($urandom_range(63)) * BPB,
               64'($urandom_range(15)) * 4096 + 64'($urandom_range(63)) * BPB,
               $urandom_range(1, 160) * BPB, $urandom_range(1, MB), -1, 3'b000, 0, 0);

    err_beat = 10;
    run_xfer(64'h1_0000_0000, 64'h0, 12288, 64, 1, 3'b001, 0, 0);
    err_beat = -1;

    clear_obs();
    src_addr = 0; dst_addr = 0; byte_count = 4096; burst_beats = 64; start = 1;
    tick(); start = 0;
    repeat (5) tick();
    check("rej_src0_status", status, 3'b101);
    check("rej_src0_idle", idle, 1'b1);
    src_addr = 64'h1_0000_0000; byte_count = 100; start = 1;
    tick(); start = 0;
    repeat (5) tick();
    check("rej_cnt_status", status[2], 1'b1);
    check("rej_cnt_idle", idle, 1'b1);
    check("rej_no_ar", obs_ar_addr.size(), 0);

    run_xfer(64'h1_0000_0000, 64'h8000, 8192, 64, -1, 3'b000, 0, 1);

    // Reset mid-WR, then an aborted restart.
    build_exp(64'h1_0000_0000, 64'h0, 8192, 64);
    clear_obs();
    src_addr = 64'h1_0000_0000; dst_addr = 0; byte_count = 8192; burst_beats = 64; start = 1;
    tick(); start = 0;
    for (int c = 0; c < 2000 && !WVALID; c++) tick();
    check("reached_wr", WVALID, 1'b1);
    reset = 1;
    #1;
    check("rst_mid_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
    check("rst_mid_idle", idle, 1'b1);
    repeat (3) tick();
    reset = 0;
    tick();
    run_xfer(64'h1_0000_0000, 64'h0, 12288, 64, 1, 3'b000, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
